// File: rtl/mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// op encodings, FSM states and datapath sizing constants.
package mul_pkg;

    localparam int N_DIGITS   = 17;
    localparam int N_COMP_CYC = 9;
    localparam int PROD_W     = 64;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMP,
        ST_ADD,
        ST_DONE
    } mul_state_e;

endpackage

// File: rtl/mul_booth_iter_if.sv
// Issue-side and writeback-side handshake bundle of the Booth multiplier.
interface mul_booth_iter_if #(
    parameter int TAG_W = 5
);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial product: recodes a 3-bit multiplier window into a
// digit in {-2..+2} and returns digit * multiplicand << 2*idx, mod 2^64.
module booth_pp_gen
    import mul_pkg::*;
(
    input  logic [2:0]        win,
    input  logic [32:0]       mcand,
    input  logic [4:0]        idx,
    output logic [PROD_W-1:0] pp
);

    logic [PROD_W-1:0] m_ext;
    logic [PROD_W-1:0] mag;

    always_comb begin
        m_ext = {{(PROD_W-33){mcand[32]}}, mcand};
        case (win)
            3'b001, 3'b010: mag = m_ext;
            3'b011:         mag = m_ext << 1;
            3'b100:         mag = -(m_ext << 1);
            3'b101, 3'b110: mag = -m_ext;
            default:        mag = '0;
        endcase
        pp = mag << {idx, 1'b0};
    end

endmodule

// File: rtl/comp_4to2.sv
// 4:2 carry-save compressor built from two chained 3:2 stages; all
// arithmetic is modulo 2^NUM, so carries out of the top bit are dropped.
module comp_4to2 #(
    parameter int NUM = 64
) (
    input  logic [NUM-1:0] a,
    input  logic [NUM-1:0] b,
    input  logic [NUM-1:0] c,
    input  logic [NUM-1:0] d,
    output logic [NUM-1:0] sum,
    output logic [NUM-1:0] carry
);

    logic [NUM-1:0] s1;
    logic [NUM-1:0] k1_sh;

    always_comb begin
        s1    = a ^ b ^ c;
        k1_sh = {(a[NUM-2:0] & b[NUM-2:0]) | (a[NUM-2:0] & c[NUM-2:0]) |
                 (b[NUM-2:0] & c[NUM-2:0]), 1'b0};
        sum   = s1 ^ d ^ k1_sh;
        carry = {(s1[NUM-2:0] & d[NUM-2:0]) | (s1[NUM-2:0] & k1_sh[NUM-2:0]) |
                 (d[NUM-2:0] & k1_sh[NUM-2:0]), 1'b0};
    end

endmodule

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU:
// two partial products per cycle folded into a carry-save accumulator.
module mul_booth_iter
    import mul_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    mul_booth_iter_if.slave  bus
);

    mul_state_e        state;
    mul_state_e        state_nxt;
    logic [3:0]        cnt;
    logic [32:0]       mcand;
    logic [37:0]       mplr;
    mul_op_e           op_in;
    mul_op_e           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic [31:0]       out_data_q;
    logic [PROD_W-1:0] acc_sum;
    logic [PROD_W-1:0] acc_carry;
    logic [PROD_W-1:0] pp_a;
    logic [PROD_W-1:0] pp_b;
    logic [PROD_W-1:0] cmp_sum;
    logic [PROD_W-1:0] cmp_carry;
    logic [PROD_W-1:0] prod;
    logic              accept;
    logic              last_comp;
    logic              sgn1;
    logic              sgn2;

    assign op_in     = mul_op_e'(bus.in_op);
    assign sgn1      = (op_in == MUL_OP_MULH) || (op_in == MUL_OP_MULHSU);
    assign sgn2      = (op_in == MUL_OP_MULH);
    assign accept    = (state == ST_IDLE) && bus.in_valid && !flush;
    assign last_comp = (cnt == 4'(N_COMP_CYC - 1));
    assign prod      = acc_sum + acc_carry;

    // Window [2:0] is digit 2k, [4:2] is digit 2k+1; the sign-filled top of
    // mplr makes the final window all-sign, so PP_17 recodes to zero.
    booth_pp_gen u_pp_a (
        .win   (mplr[2:0]),
        .mcand (mcand),
        .idx   ({cnt, 1'b0}),
        .pp    (pp_a)
    );

    booth_pp_gen u_pp_b (
        .win   (mplr[4:2]),
        .mcand (mcand),
        .idx   ({cnt, 1'b1}),
        .pp    (pp_b)
    );

    comp_4to2 #(.NUM(PROD_W)) u_comp (
        .a     (pp_a),
        .b     (pp_b),
        .c     (acc_sum),
        .d     (acc_carry),
        .sum   (cmp_sum),
        .carry (cmp_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_nxt = ST_COMP;
            ST_COMP: if (last_comp)     state_nxt = ST_ADD;
            ST_ADD:                     state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        bus.out_data  = out_data_q;
        bus.out_tag   = out_tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            op_q       <= MUL_OP_MUL;
            tag_q      <= '0;
            acc_sum    <= '0;
            acc_carry  <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else if (accept) begin
            cnt       <= '0;
            mcand     <= {sgn1 & bus.in_rs1[31], bus.in_rs1};
            mplr      <= {{5{sgn2 & bus.in_rs2[31]}}, bus.in_rs2, 1'b0};
            op_q      <= op_in;
            tag_q     <= bus.in_tag;
            acc_sum   <= '0;
            acc_carry <= '0;
        end else if (state == ST_COMP) begin
            cnt       <= cnt + 4'd1;
            mplr      <= {{4{mplr[37]}}, mplr[37:4]};
            acc_sum   <= cmp_sum;
            acc_carry <= cmp_carry;
        end else if (state == ST_ADD) begin
            out_data_q <= (op_q == MUL_OP_MUL) ? prod[31:0] : prod[63:32];
            out_tag_q  <= tag_q;
        end
    end

endmodule

// File: tb/tb_mul_booth_iter.sv
// Directed and randomised self-checking bench for mul_booth_iter.
module tb_mul_booth_iter;

    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    mul_booth_iter_if #(.TAG_W(TAG_W)) bus ();

    mul_booth_iter #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        bx = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ax * bx;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_tag   = tag;
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_timeout: out_valid=%b required 1", bus.out_valid);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = 2'b11;
        bus.in_rs1    = 32'hDEAD_BEEF;
        bus.in_rs2    = 32'h1234_5678;
        bus.in_tag    = 5'h1F;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++; $display("FAIL reset_out_data: got %h required 0", bus.out_data);
        end
        checks++;
        if (bus.out_tag !== 5'h0) begin
            errors++; $display("FAIL reset_out_tag: got %h required 0", bus.out_tag);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_mul_basic();
        int lat;
        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 5'h0A);
        wait_valid(lat);
        checks++;
        if (lat !== 10) begin
            errors++; $display("FAIL mul_latency: got %0d edges required 10", lat);
        end
        checks++;
        if (bus.out_data !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mul_data: got %h required ffffffeb", bus.out_data);
        end
        checks++;
        if (bus.out_tag !== 5'h0A) begin
            errors++; $display("FAIL mul_tag: got %h required 0a", bus.out_tag);
        end
        handshake();
    endtask

    task automatic test_ops();
        logic [1:0]  ops [9];
        logic [31:0] va  [9];
        logic [31:0] vb  [9];
        logic [31:0] ve  [9];
        int lat;
        ops = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
        va  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h8000_0000,
                32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000, 32'h1234_5678};
        vb  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0002, 32'h0000_0010};
        ve  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,
                32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h2345_6780};
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], va[i], vb[i], 5'(i + 1));
            wait_valid(lat);
            checks++;
            if (bus.out_data !== ve[i]) begin
                errors++;
                $display("FAIL op_vec%0d_data: got %h required %h", i, bus.out_data, ve[i]);
            end
            checks++;
            if (bus.out_tag !== 5'(i + 1)) begin
                errors++;
                $display("FAIL op_vec%0d_tag: got %h required %h", i, bus.out_tag, 5'(i + 1));
            end
            handshake();
        end
    endtask

    task automatic test_stall();
        int lat;
        issue(2'b11, 32'h1234_5678, 32'h0000_0010, 5'h11);
        wait_valid(lat);
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b00;
        bus.in_rs1   = 32'd3;
        bus.in_rs2   = 32'd5;
        bus.in_tag   = 5'h12;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_valid c%0d: got %b required 1", i, bus.out_valid);
            end
            checks++;
            if (bus.out_data !== 32'h0000_0001) begin
                errors++; $display("FAIL stall_data c%0d: got %h required 00000001", i, bus.out_data);
            end
            checks++;
            if (bus.out_tag !== 5'h11) begin
                errors++; $display("FAIL stall_tag c%0d: got %h required 11", i, bus.out_tag);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready c%0d: got %b required 0", i, bus.in_ready);
            end
            @(negedge clk);
        end
        handshake();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake_idle: in_ready=%b out_valid=%b required 1/0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL resume_accept: in_ready=%b required 0", bus.in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL resume_latency: got %0d required 9", lat);
        end
        checks++;
        if (bus.out_data !== 32'd15 || bus.out_tag !== 5'h12) begin
            errors++;
            $display("FAIL resume_result: got %h/%h required 0000000f/12", bus.out_data, bus.out_tag);
        end
        handshake();
    endtask

    task automatic test_flush();
        int lat;
        bit seen;
        // flush in COMP cycle 4
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_comp: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL flush_comp_quiet: out_valid seen=%b required 0", seen);
        end
        // flush while a result waits in DONE
        issue(2'b00, 32'd9, 32'd9, 5'h04);
        wait_valid(lat);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        // flush beats a simultaneous request
        bus.in_valid = 1'b1;
        bus.in_op    = 2'b00;
        bus.in_rs1   = 32'd2;
        bus.in_rs2   = 32'd2;
        bus.in_tag   = 5'h05;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_priority: in_ready=%b required 1", bus.in_ready);
        end
        seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL flush_priority_quiet: out_valid seen=%b required 0", seen);
        end
        // reset mid-operation
        issue(2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'h06);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_midop: in_ready=%b out_valid=%b out_data=%h required 1/0/0",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
        issue(2'b00, 32'd3, 32'd5, 5'h07);
        wait_valid(lat);
        checks++;
        if (lat !== 10) begin
            errors++; $display("FAIL post_flush_latency: got %0d required 10", lat);
        end
        checks++;
        if (bus.out_data !== 32'd15 || bus.out_tag !== 5'h07) begin
            errors++;
            $display("FAIL post_flush_result: got %h/%h required 0000000f/07", bus.out_data, bus.out_tag);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ve [4];
        int lat;
        int prev;
        ve = '{32'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
        bus.out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: issue(2'b00, 32'd2, 32'd3, 5'h08);
                1: issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 5'h09);
                2: issue(2'b10, 32'h0000_0002, 32'h8000_0000, 5'h0A);
                default: issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h0B);
            endcase
            if (i > 0) begin
                checks++;
                if (acc_cyc - prev !== 12) begin
                    errors++;
                    $display("FAIL b2b_interval%0d: got %0d cycles required 12", i, acc_cyc - prev);
                end
            end
            prev = acc_cyc;
            wait_valid(lat);
            checks++;
            if (bus.out_data !== ve[i] || bus.out_tag !== 5'(8 + i)) begin
                errors++;
                $display("FAIL b2b_result%0d: got %h/%h required %h/%h",
                         i, bus.out_data, bus.out_tag, ve[i], 5'(8 + i));
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, exp;
        int lat;
        for (int i = 0; i < 300; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = pick();
            b   = pick();
            exp = ref_mul(op, a, b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(op, a, b, 5'(i));
            wait_valid(lat);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            checks++;
            if (bus.out_data !== exp) begin
                errors++;
                $display("FAIL rand%0d_data op=%0d a=%h b=%h: got %h required %h",
                         i, op, a, b, bus.out_data, exp);
            end
            checks++;
            if (bus.out_tag !== 5'(i)) begin
                errors++; $display("FAIL rand%0d_tag: got %h required %h", i, bus.out_tag, 5'(i));
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_ops();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
